// File: rtl/viterbi_arbiter.sv
// Round-robin arbiter that streams one requester's coded frame into a shared
// Viterbi decoder and routes the decoded bits back to the frame owner.
module viterbi_arbiter #(
    parameter int MAX_BITS = 32767,
    parameter int TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        req0,
    input  logic        req1,
    input  logic        valid0,
    input  logic        valid1,
    input  logic        data0,
    input  logic        data1,
    input  logic        last0,
    input  logic        last1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        dec_valid_in,
    output logic        dec_data_in,
    output logic        dec_enable,
    output logic        dec_flush,
    input  logic        dec_valid_out,
    input  logic        dec_data_out,
    input  logic        dec_finished,
    output logic        out_valid0,
    output logic        out_valid1,
    output logic        out_data0,
    output logic        out_data1,
    output logic        done0,
    output logic        done1,
    output logic        busy,
    output logic [14:0] bit_count,
    output logic        ovf_err,
    output logic        tmo_err
);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        LAUNCH,
        DECODE,
        RELEASE
    } state_t;

    localparam logic [14:0] MAXB = 15'(MAX_BITS);
    localparam logic [15:0] TMO  = 16'(TIMEOUT);

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic        armed_q;
    logic [15:0] tmo_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        dvi_q;
    logic        ddi_q;
    logic        den_q;
    logic        dfl_q;
    logic        done0_q;
    logic        done1_q;
    logic        busy_q;
    logic [14:0] bit_count_q;
    logic        ovf_q;
    logic        tmo_err_q;

    logic        win;
    logic        own_valid;
    logic        own_data;
    logic        own_last;
    logic [14:0] bc_d;
    logic [15:0] tmo_d;
    logic        in_dec;

    // On a tie the requester not served last wins.
    assign win       = (req0 & req1) ? ~last_q : ~req0;
    assign own_valid = owner_q ? valid1 : valid0;
    assign own_data  = owner_q ? data1 : data0;
    assign own_last  = owner_q ? last1 : last0;
    assign bc_d      = (bit_count_q == MAXB) ? bit_count_q
                                             : bit_count_q + 15'd1;
    assign tmo_d     = tmo_q + 16'd1;
    assign in_dec    = (state_q == DECODE);

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            armed_q     <= 1'b0;
            tmo_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            dvi_q       <= 1'b0;
            ddi_q       <= 1'b0;
            den_q       <= 1'b0;
            dfl_q       <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            busy_q      <= 1'b0;
            bit_count_q <= '0;
            ovf_q       <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            dvi_q   <= 1'b0;
            dfl_q   <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // armed_q delays the first grant by one edge after reset.
                    if (armed_q && (req0 || req1)) begin
                        state_q     <= STREAM;
                        owner_q     <= win;
                        gnt0_q      <= ~win;
                        gnt1_q      <= win;
                        bit_count_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                STREAM: begin
                    dvi_q <= own_valid;
                    ddi_q <= own_data;
                    if (own_valid) begin
                        bit_count_q <= bc_d;
                        if (own_last) begin
                            state_q <= LAUNCH;
                        end else if (bc_d == MAXB) begin
                            ovf_q   <= 1'b1;
                            state_q <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    den_q   <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= DECODE;
                end
                DECODE: begin
                    tmo_q <= tmo_d;
                    if (dec_finished || tmo_d == TMO) begin
                        if (!dec_finished) begin
                            dfl_q     <= 1'b1;
                            tmo_err_q <= 1'b1;
                        end
                        den_q   <= 1'b0;
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign dec_valid_in = dvi_q;
    assign dec_data_in  = ddi_q;
    assign dec_enable   = den_q;
    assign dec_flush    = dfl_q;
    assign done0        = done0_q;
    assign done1        = done1_q;
    assign busy         = busy_q;
    assign bit_count    = bit_count_q;
    assign ovf_err      = ovf_q;
    assign tmo_err      = tmo_err_q;
    assign out_valid0   = in_dec & ~owner_q & dec_valid_out;
    assign out_valid1   = in_dec & owner_q & dec_valid_out;
    assign out_data0    = in_dec & ~owner_q & dec_data_out;
    assign out_data1    = in_dec & owner_q & dec_data_out;

endmodule

// File: tb/tb_viterbi_arbiter.sv
// Directed bench for viterbi_arbiter: single frame, round-robin ties,
// overflow, timeout, finish/timeout collision and reset mid-decode.
module tb_viterbi_arbiter;

    logic        clk = 1'b0;
    logic        RESET;
    logic        req0, req1, valid0, valid1, data0, data1, last0, last1;
    logic        gnt0, gnt1, dec_valid_in, dec_data_in, dec_enable, dec_flush;
    logic        dec_valid_out, dec_data_out, dec_finished;
    logic        out_valid0, out_valid1, out_data0, out_data1;
    logic        done0, done1, busy, ovf_err, tmo_err;
    logic [14:0] bit_count;

    int checks = 0;
    int errors = 0;

    viterbi_arbiter #(.MAX_BITS(16), .TIMEOUT(20)) dut (
        .clk(clk), .RESET(RESET),
        .req0(req0), .req1(req1),
        .valid0(valid0), .valid1(valid1),
        .data0(data0), .data1(data1),
        .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1),
        .dec_valid_in(dec_valid_in), .dec_data_in(dec_data_in),
        .dec_enable(dec_enable), .dec_flush(dec_flush),
        .dec_valid_out(dec_valid_out), .dec_data_out(dec_data_out),
        .dec_finished(dec_finished),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_data0(out_data0), .out_data1(out_data1),
        .done0(done0), .done1(done1), .busy(busy),
        .bit_count(bit_count), .ovf_err(ovf_err), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-bit frame for requester w, decoder finishes in its first cycle.
    task automatic frame1(input logic w);
        if (w) begin valid1 = 1; last1 = 1; end
        else   begin valid0 = 1; last0 = 1; end
        tick();
        valid0 = 0; last0 = 0; valid1 = 0; last1 = 0;
        tick();
        chk("f1_den", dec_enable, 1);
        dec_finished = 1;
        tick();
        chk("f1_done", w ? done1 : done0, 1);
        dec_finished = 0;
        tick();
    endtask

    logic [7:0] pat;

    initial begin
        RESET = 0;
        req0 = 0; req1 = 0; valid0 = 0; valid1 = 0;
        data0 = 0; data1 = 0; last0 = 0; last1 = 0;
        dec_valid_out = 0; dec_data_out = 0; dec_finished = 0;
        pat = 8'b1011_0010;
        tick(); tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bc", bit_count, 0);
        chk("rst_errs", {ovf_err, tmo_err, dec_enable, dec_flush}, 0);

        // Single frame from requester 0.
        req0 = 1;
        RESET = 1;
        tick();
        chk("arm_nogrant", gnt0, 0);
        tick();
        chk("grant0", {gnt1, gnt0, busy}, 3'b011);
        chk("grant_bc0", bit_count, 0);
        valid1 = 1; data1 = 1; last1 = 1; dec_finished = 1;
        for (int i = 0; i < 8; i++) begin
            valid0 = 1; data0 = pat[i]; last0 = (i == 7);
            if (i == 1) req0 = 0;
            tick();
            chk("s_dvi", dec_valid_in, 1);
            chk("s_ddi", dec_data_in, pat[i]);
            chk("s_bc", bit_count, i + 1);
        end
        valid0 = 0; last0 = 0; valid1 = 0; data1 = 0; last1 = 0;
        chk("launch_den", dec_enable, 0);
        dec_finished = 0;
        tick();
        chk("dec_den", dec_enable, 1);
        chk("dec_dvi", dec_valid_in, 0);
        chk("dec_gnt0", gnt0, 1);
        dec_valid_out = 1; dec_data_out = 1;
        #1;
        chk("route0", {out_valid1, out_data1, out_valid0, out_data0}, 4'b0011);
        dec_data_out = 0;
        #1;
        chk("route0b", {out_valid1, out_data1, out_valid0, out_data0}, 4'b0010);
        dec_valid_out = 0; dec_finished = 1;
        tick();
        chk("rel", {done1, done0, dec_enable, busy}, 4'b0101);
        dec_finished = 0;
        tick();
        chk("idle", {done0, gnt0, busy}, 0);
        chk("idle_bc", bit_count, 8);

        // Round-robin from reset with both requesters held.
        RESET = 0;
        #1;
        RESET = 1;
        req0 = 1; req1 = 1;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk("rr_gnt", {gnt1, gnt0}, (k % 2) ? 2'b10 : 2'b01);
            if (k == 3) begin req0 = 0; req1 = 0; end
            frame1(k % 2 == 1);
            if (k < 3) tick();
        end
        chk("rr_idle", busy, 0);

        // Overflow at 16 bits, then decode timeout after 20 cycles.
        req1 = 1;
        tick();
        chk("ovf_gnt1", gnt1, 1);
        for (int i = 0; i < 16; i++) begin
            valid1 = 1; data1 = i[0];
            tick();
            if (i == 14) chk("ovf_pre", {ovf_err, 15'(bit_count)}, 16'd15);
        end
        valid1 = 0; req1 = 0;
        chk("ovf_set", ovf_err, 1);
        chk("ovf_bc", bit_count, 16);
        tick();
        chk("ovf_den", dec_enable, 1);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("tmo_wait", {dec_flush, dec_enable}, 2'b01);
        end
        tick();
        chk("tmo_pulse", {dec_flush, tmo_err, done1, dec_enable}, 4'b1110);
        tick();
        chk("tmo_end", {dec_flush, done1, busy, tmo_err}, 4'b0001);

        // Finish collides with timeout: finish wins.
        RESET = 0;
        #1;
        chk("rst_sticky", {ovf_err, tmo_err}, 0);
        RESET = 1;
        req0 = 1;
        tick(); tick();
        req0 = 0;
        valid0 = 1; last0 = 1;
        tick();
        valid0 = 0; last0 = 0;
        tick();
        for (int i = 1; i < 20; i++) tick();
        dec_finished = 1;
        tick();
        chk("col", {dec_flush, tmo_err, done0}, 3'b001);
        dec_finished = 0;
        tick();

        // Reset during DECODE drops the frame.
        req0 = 1;
        tick();
        chk("mid_gnt0", gnt0, 1);
        req0 = 0;
        valid0 = 1; last0 = 1;
        tick();
        valid0 = 0; last0 = 0;
        tick();
        dec_valid_out = 1; dec_data_out = 1;
        #1;
        chk("mid_route", out_valid0, 1);
        RESET = 0;
        #1;
        chk("mid_rst", {gnt0, dec_enable, busy, out_valid0, out_data0}, 0);
        chk("mid_rst_bc", bit_count, 0);
        dec_valid_out = 0; dec_data_out = 0; dec_finished = 1;
        tick();
        chk("mid_nodone", {done0, done1}, 0);
        dec_finished = 0;
        RESET = 1;
        req0 = 1;
        tick(); tick();
        chk("mid_regrant", {gnt1, gnt0}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
